tdoa_collector: RTL and testbench

Downstream consumer of the per-microphone Timer stages in the microphone pre-processing core. It takes the held timestamp/valid pair from each channel and acknowledges it. Captures belonging to one acoustic event are grouped into a frame, bounded by a cycle window. Complete or timed-out frames go into a small show-ahead FIFO that the processor-side logic reads for time-difference-of-arrival computation.

---
 rtl/tdoa_collector_pkg.sv | 21 ++
 rtl/tdoa_collector_frame_fifo.sv | 68 ++++++
 rtl/tdoa_collector.sv | 130 +++++++++++++
 tb/tdoa_collector_tb_note.sv | 4 +
 tb/tb_tdoa_collector.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdoa_collector_pkg.sv
// Shared types and widths for the TDOA frame collector.
// Pure declarations; no timing or flow-control behaviour of its own.
package tdoa_collector_pkg;

   localparam int TS_W     = 32;
   localparam int N_CH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUSH    = 2'd2
   } state_e;

   // One FIFO word: capture mask above the concatenated timestamps.
   function automatic int frame_w(input int n_ch);
      return TS_W * n_ch + n_ch;
   endfunction

   localparam int FRAME_W_DEF = TS_W * N_CH_DEF + N_CH_DEF;

endpackage

// File: rtl/tdoa_collector_frame_fifo.sv
// Synchronous show-ahead FIFO: head word visible while non-empty, pop takes effect at the edge.
// A write when full is dropped unless a pop happens on the same edge; reads while empty are ignored.
module frame_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;

   assign empty_o  = (cnt_q == '0);
   assign full_o   = (cnt_q == CW'(DEPTH));
   assign pop      = rd_en_i && !empty_o;
   assign push     = wr_en_i && (!full_o || pop);
   // Empty FIFO presents an all-zero head so stale words never leak out.
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/tdoa_collector.sv
// Groups per-channel timer captures into windowed frames and queues them for TDOA readout.
// Ack one cycle after capture; frame visible 2 cycles after its last capture; full FIFO drops frames (sticky overflow).
module tdoa_collector
   import tdoa_collector_pkg::*;
#(
   parameter int N_CH   = N_CH_DEF,
   parameter int WINDOW = 500000,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TS_W*N_CH-1:0] timer_in,
   input  logic [N_CH-1:0]      timer_valid,
   output logic [N_CH-1:0]      ack,
   output logic                 frame_valid,
   output logic [TS_W*N_CH-1:0] frame_data,
   output logic [N_CH-1:0]      frame_mask,
   input  logic                 frame_rd,
   output logic                 overflow,
   input  logic                 ovf_clr
);

   localparam int          DW       = TS_W * N_CH;
   localparam int          FW       = frame_w(N_CH);
   localparam logic [31:0] WIN_LAST = 32'(WINDOW - 1);

   state_e          state_q, state_d;
   logic [N_CH-1:0] cap_mask_q, cap_mask_d;
   logic [N_CH-1:0] cap_en;
   logic [N_CH-1:0] ack_q;
   logic [DW-1:0]   data_q, data_d;
   logic [31:0]     win_cnt_q, win_cnt_d;
   logic            ovf_q, ovf_d;
   logic            push_req;
   logic            fifo_full, fifo_empty;
   logic [FW-1:0]   fifo_rd_dat;

   always_comb begin
      state_d    = state_q;
      win_cnt_d  = win_cnt_q;
      push_req   = 1'b0;
      cap_en     = '0;
      data_d     = data_q;

      // A channel already in the frame stays held by its timer and opens the next frame.
      if (state_q != PUSH) begin
         cap_en = timer_valid & ~cap_mask_q;
      end
      cap_mask_d = cap_mask_q | cap_en;
      for (int i = 0; i < N_CH; i++) begin
         if (cap_en[i]) begin
            data_d[i*TS_W +: TS_W] = timer_in[i*TS_W +: TS_W];
         end
      end

      case (state_q)
         IDLE: begin
            if (|timer_valid) begin
               state_d   = COLLECT;
               win_cnt_d = '0;
            end
         end
         COLLECT: begin
            win_cnt_d = win_cnt_q + 32'd1;
            // Uses the post-capture mask so a completing capture ends the frame at once.
            if ((&cap_mask_d) || (win_cnt_q == WIN_LAST)) begin
               state_d = PUSH;
            end
         end
         PUSH: begin
            push_req   = 1'b1;
            cap_mask_d = '0;
            data_d     = '0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // When full the head is valid, so a pop on this edge is exactly frame_rd.
   always_comb begin
      ovf_d = ovf_q;
      if (push_req && fifo_full && !frame_rd) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cap_mask_q <= '0;
         data_q     <= '0;
         win_cnt_q  <= '0;
         ack_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cap_mask_q <= cap_mask_d;
         data_q     <= data_d;
         win_cnt_q  <= win_cnt_d;
         ack_q      <= cap_en;
         ovf_q      <= ovf_d;
      end
   end

   frame_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_frame_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (push_req),
      .wr_dat_i ({cap_mask_q, data_q}),
      .rd_en_i  (frame_rd),
      .rd_dat_o (fifo_rd_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign ack         = ack_q;
   assign overflow    = ovf_q;
   assign frame_valid = !fifo_empty;
   assign frame_mask  = fifo_rd_dat[FW-1 -: N_CH];
   assign frame_data  = fifo_rd_dat[DW-1:0];

endmodule

// File: tb/tdoa_collector_tb_note.sv
// Intentionally empty companion file kept for include-path symmetry.
package tdoa_collector_tb_note_pkg;
   localparam int TB_NOTE_UNUSED = 0;
endpackage

// File: tb/tb_tdoa_collector.sv
// Randomized and directed bench for tdoa_collector with a timer emulator and frame-level reference model.
module tb_tdoa_collector;

   localparam int N_CH   = 4;
   localparam int WINDOW = 50;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [3:0]   m;
      logic [127:0] d;
   } frm_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] timer_in;
   logic [3:0]   timer_valid;
   logic [3:0]   ack;
   logic         frame_valid;
   logic [127:0] frame_data;
   logic [3:0]   frame_mask;
   logic         frame_rd;
   logic         overflow;
   logic         ovf_clr;

   always #5 clk = ~clk;

   tdoa_collector #(
      .N_CH   (N_CH),
      .WINDOW (WINDOW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .timer_in    (timer_in),
      .timer_valid (timer_valid),
      .ack         (ack),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_mask  (frame_mask),
      .frame_rd    (frame_rd),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic [3:0]  prev_ack;
   int          ack_cnt [4];
   frm_t        exp_q [$];
   logic        exp_ovf;
   int          sched_off [4];
   logic [31:0] sched_ts [4];
   logic [3:0]  sched_en;

   // One clock; the timer emulator drops valid one edge after it saw ack.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      timer_valid = timer_valid & ~prev_ack;
      prev_ack    = ack;
      for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
   endtask

   task automatic present(input int ch, input logic [31:0] ts);
      timer_in[ch*32 +: 32] = ts;
      timer_valid[ch]       = 1'b1;
   endtask

   task automatic clear_acks();
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
   endtask

   task automatic model_push(input frm_t f);
      if (exp_q.size() < DEPTH) exp_q.push_back(f);
      else exp_ovf = 1'b1;
   endtask

   // Frame timing rules: complete in IDLE -> +3, complete in COLLECT -> last+2, else first+WINDOW+2.
   task automatic run_sched(input string name);
      frm_t f;
      frm_t h;
      int   c0, maxoff, exp_vis, seen;
      f.m = sched_en;
      f.d = '0;
      maxoff = 0;
      for (int i = 0; i < 4; i++) begin
         if (sched_en[i]) begin
            f.d[i*32 +: 32] = sched_ts[i];
            if (sched_off[i] > maxoff) maxoff = sched_off[i];
         end
      end
      exp_vis = (sched_en == 4'hF) ? ((maxoff == 0) ? 3 : maxoff + 2) : WINDOW + 2;
      clear_acks();
      c0   = cyc;
      seen = -1;
      for (int t = 0; t <= WINDOW + 10 && seen < 0; t++) begin
         for (int i = 0; i < 4; i++) if (sched_en[i] && sched_off[i] == t) present(i, sched_ts[i]);
         step();
         if (frame_valid && seen < 0) seen = cyc - c0;
      end
      checks++;
      if (seen != exp_vis) begin
         errors++;
         $display("FAIL %s_latency got=%0d want=%0d", name, seen, exp_vis);
      end
      model_push(f);
      h = exp_q.pop_front();
      checks++;
      if ({frame_mask, frame_data} !== {h.m, h.d}) begin
         errors++;
         $display("FAIL %s_frame got mask=%b data=%h want mask=%b data=%h", name, frame_mask, frame_data, h.m, h.d);
      end
      frame_rd = 1'b1;
      step();
      frame_rd = 1'b0;
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_pop frame_valid got=%b want=0", name, frame_valid);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ack_cnt[i] != int'(sched_en[i])) begin
            errors++;
            $display("FAIL %s_ack_ch%0d pulses got=%0d want=%0d", name, i, ack_cnt[i], int'(sched_en[i]));
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++;
      if ({ack, frame_valid, frame_mask, frame_data, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b fv=%b mask=%b ovf=%b want all 0", ack, frame_valid, frame_mask, overflow);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({ack, frame_valid, overflow} !== 3'b0 && ack !== 4'b0) begin
         errors++;
         $display("FAIL post_reset_idle got ack=%b fv=%b ovf=%b want 0", ack, frame_valid, overflow);
      end
   endtask

   task automatic test_simultaneous();
      frm_t f;
      f.m = 4'hF;
      f.d = '0;
      clear_acks();
      for (int i = 0; i < 4; i++) begin
         present(i, 32'd100);
         f.d[i*32 +: 32] = 32'd100;
      end
      step();
      checks++;
      if (ack !== 4'hF) begin
         errors++;
         $display("FAIL simul_ack got=%b want=1111", ack);
      end
      step();
      checks++;
      if ({ack, frame_valid} !== 5'b0) begin
         errors++;
         $display("FAIL simul_early got ack=%b fv=%b want 0", ack, frame_valid);
      end
      step();
      checks++;
      if (frame_valid !== 1'b1 || {frame_mask, frame_data} !== {f.m, f.d}) begin
         errors++;
         $display("FAIL simul_frame got fv=%b mask=%b data=%h want fv=1 mask=%b data=%h", frame_valid, frame_mask, frame_data, f.m, f.d);
      end
      frame_rd = 1'b1;
      step();
      frame_rd = 1'b0;
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_pop frame_valid got=%b want=0", frame_valid);
      end
   endtask

   task automatic test_staggered();
      sched_en  = 4'hF;
      sched_off = '{0, 20, 10, 30};
      sched_ts  = '{32'd1000, 32'd1020, 32'd1010, 32'd1030};
      run_sched("staggered");
   endtask

   task automatic test_timeout();
      sched_en  = 4'b1001;
      sched_off = '{0, 0, 0, 4};
      sched_ts  = '{32'd5, 32'd0, 32'd0, 32'd9};
      run_sched("timeout");
   endtask

   task automatic test_retrigger();
      int   c0, seen;
      frm_t f;
      clear_acks();
      c0   = cyc;
      seen = -1;
      present(1, 32'd7);
      for (int k = 1; k <= WINDOW + 2; k++) begin
         step();
         if (k == 5) present(1, 32'd40);
         if (frame_valid && seen < 0) seen = k;
      end
      checks++;
      if (seen != WINDOW + 2 || ack_cnt[1] != 1) begin
         errors++;
         $display("FAIL retrig_first got seen=%0d acks=%0d want seen=%0d acks=1", seen, ack_cnt[1], WINDOW + 2);
      end
      f.m = 4'b0010;
      f.d = '0;
      f.d[63:32] = 32'd7;
      checks++;
      if ({frame_mask, frame_data} !== {f.m, f.d}) begin
         errors++;
         $display("FAIL retrig_frame1 got mask=%b data=%h want mask=%b data=%h", frame_mask, frame_data, f.m, f.d);
      end
      frame_rd = 1'b1;
      step();
      frame_rd = 1'b0;
      checks++;
      if (ack !== 4'b0010 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL retrig_reack got ack=%b fv=%b want ack=0010 fv=0", ack, frame_valid);
      end
      seen = -1;
      for (int k = WINDOW + 4; k <= 2 * WINDOW + 10 && seen < 0; k++) begin
         step();
         if (frame_valid) seen = cyc - c0;
      end
      f.d[63:32] = 32'd40;
      checks++;
      if (seen != 2 * WINDOW + 4 || {frame_mask, frame_data} !== {f.m, f.d}) begin
         errors++;
         $display("FAIL retrig_frame2 got seen=%0d mask=%b data=%h want seen=%0d mask=%b data=%h", seen, frame_mask, frame_data, 2 * WINDOW + 4, f.m, f.d);
      end
      frame_rd = 1'b1;
      step();
      frame_rd = 1'b0;
      checks++;
      if (ack_cnt[1] != 2) begin
         errors++;
         $display("FAIL retrig_ackcount got=%0d want=2", ack_cnt[1]);
      end
   endtask

   task automatic test_overflow();
      frm_t f;
      frm_t h;
      exp_ovf = 1'b0;
      for (int n = 0; n < 5; n++) begin
         f.m = 4'hF;
         f.d = '0;
         for (int i = 0; i < 4; i++) begin
            present(i, 32'h1000_0000 + 32'(n * 16 + i));
            f.d[i*32 +: 32] = 32'h1000_0000 + 32'(n * 16 + i);
         end
         if (n == 4) ovf_clr = 1'b1;
         repeat (3) step();
         ovf_clr = 1'b0;
         model_push(f);
         step();
      end
      checks++;
      if (overflow !== exp_ovf || frame_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got ovf=%b fv=%b want ovf=%b fv=1", overflow, frame_valid, exp_ovf);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      checks++;
      if (overflow !== exp_ovf) begin
         errors++;
         $display("FAIL ovf_clr got=%b want=%b", overflow, exp_ovf);
      end
      for (int n = 0; n < 4; n++) begin
         h = exp_q.pop_front();
         checks++;
         if (frame_valid !== 1'b1 || {frame_mask, frame_data} !== {h.m, h.d}) begin
            errors++;
            $display("FAIL ovf_pop%0d got fv=%b mask=%b data=%h want mask=%b data=%h", n, frame_valid, frame_mask, frame_data, h.m, h.d);
         end
         frame_rd = 1'b1;
         step();
         frame_rd = 1'b0;
      end
      checks++;
      if ({frame_valid, frame_mask, frame_data} !== '0) begin
         errors++;
         $display("FAIL ovf_drained got fv=%b mask=%b data=%h want all 0", frame_valid, frame_mask, frame_data);
      end
      frame_rd = 1'b1;
      step();
      frame_rd = 1'b0;
   endtask

   task automatic test_full_push_pop();
      frm_t f;
      frm_t h;
      for (int n = 0; n < 5; n++) begin
         f.m = 4'hF;
         f.d = '0;
         for (int i = 0; i < 4; i++) begin
            present(i, 32'h2000_0000 + 32'(n * 16 + i));
            f.d[i*32 +: 32] = 32'h2000_0000 + 32'(n * 16 + i);
         end
         if (n < 4) begin
            repeat (4) step();
            model_push(f);
         end else begin
            repeat (2) step();
            h = exp_q.pop_front();
            checks++;
            if ({frame_mask, frame_data} !== {h.m, h.d}) begin
               errors++;
               $display("FAIL fullpp_head got mask=%b data=%h want mask=%b data=%h", frame_mask, frame_data, h.m, h.d);
            end
            frame_rd = 1'b1;
            step();
            frame_rd = 1'b0;
            model_push(f);
            step();
         end
      end
      checks++;
      if (overflow !== exp_ovf) begin
         errors++;
         $display("FAIL fullpp_ovf got=%b want=%b", overflow, exp_ovf);
      end
      for (int n = 0; n < 4; n++) begin
         h = exp_q.pop_front();
         checks++;
         if (frame_valid !== 1'b1 || {frame_mask, frame_data} !== {h.m, h.d}) begin
            errors++;
            $display("FAIL fullpp_pop%0d got fv=%b mask=%b data=%h want mask=%b data=%h", n, frame_valid, frame_mask, frame_data, h.m, h.d);
         end
         frame_rd = 1'b1;
         step();
         frame_rd = 1'b0;
      end
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL fullpp_empty fv got=%b want=0", frame_valid);
      end
   endtask

   task automatic test_random();
      int lo, hi;
      for (int n = 0; n < 20; n++) begin
         sched_en = 4'($urandom_range(15, 1));
         if (n % 4 == 0) sched_en = 4'hF;
         lo = -1;
         hi = -1;
         for (int i = 0; i < 4; i++) begin
            if (sched_en[i]) begin
               if (lo < 0) lo = i;
               hi = i;
            end
            sched_ts[i]  = $urandom();
            sched_off[i] = (n % 3 == 0) ? int'($urandom_range(3, 0)) : int'($urandom_range(WINDOW, 0));
         end
         sched_off[lo] = 0;
         if (n % 5 == 1 && hi != lo) sched_off[hi] = WINDOW;
         run_sched("random");
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) present(i, 32'hAAAA_0000 + 32'(i));
      repeat (4) step();
      present(0, 32'd11);
      present(2, 32'd22);
      step();
      checks++;
      if (ack !== 4'b0101) begin
         errors++;
         $display("FAIL rstmid_ack got=%b want=0101", ack);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({ack, frame_valid, frame_mask, frame_data, overflow} !== '0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async got ack=%b fv=%b mask=%b ovf=%b want all 0", ack, frame_valid, frame_mask, overflow);
      end
      timer_valid = '0;
      prev_ack    = '0;
      exp_q.delete();
      exp_ovf = 1'b0;
      repeat (2) step();
      checks++;
      if ({ack, frame_valid, frame_mask, frame_data, overflow} !== '0) begin
         errors++;
         $display("FAIL rstmid_held got ack=%b fv=%b mask=%b ovf=%b want all 0", ack, frame_valid, frame_mask, overflow);
      end
      rst = 1'b1;
      step();
      sched_en  = 4'b0010;
      sched_off = '{0, 0, 0, 0};
      sched_ts  = '{32'd0, 32'd33, 32'd0, 32'd0};
      run_sched("rstmid_fresh");
   endtask

   initial begin
      rst         = 1'b0;
      timer_in    = '0;
      timer_valid = '0;
      frame_rd    = 1'b0;
      ovf_clr     = 1'b0;
      prev_ack    = '0;
      exp_ovf     = 1'b0;
      clear_acks();
      test_reset();
      test_simultaneous();
      test_staggered();
      test_timeout();
      test_retrigger();
      test_overflow();
      test_full_push_pop();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
